twpm_ram_arbiter: RTL and testbench

TWPM_RAM_ARBITER -- requirements
Module: twpm_ram_arbiter

---
 rtl/twpm_ram_pkg.sv | 21 ++
 rtl/twpm_byte_lane.sv | 31 +++
 rtl/twpm_ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_twpm_ram_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/twpm_ram_pkg.sv
// Shared types and defaults for the TWPM buffer RAM arbiter.
// Used by the arbiter top and its byte-lane steering block.
package twpm_ram_pkg;

  localparam int         WORD_AW_DEF   = 9;
  localparam logic [7:0] FILL_BYTE_DEF = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_CAPTURE,
    ST_REJECT
  } arb_state_e;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_e;

endpackage

// File: rtl/twpm_byte_lane.sv
// Maps the byte-wide port A onto the 32-bit RAM word: address, write
// replication, byte enable and read-byte selection.
module twpm_byte_lane
  import twpm_ram_pkg::*;
#(
  parameter int WORD_AW = WORD_AW_DEF
) (
  input  logic [WORD_AW+1:0] a_addr,
  input  logic [7:0]         a_wdata,
  input  logic [31:0]        ram_rdata,
  output logic [WORD_AW-1:0] word_addr,
  output logic [31:0]        word_wdata,
  output logic [3:0]         word_be,
  output logic [7:0]         byte_rdata
);

  assign word_addr  = a_addr[WORD_AW+1:2];
  assign word_wdata = {4{a_wdata}};

  always_comb begin
    word_be    = 4'b0000;
    byte_rdata = 8'h00;
    case (a_addr[1:0])
      2'd0: begin word_be = 4'b0001; byte_rdata = ram_rdata[7:0];   end
      2'd1: begin word_be = 4'b0010; byte_rdata = ram_rdata[15:8];  end
      2'd2: begin word_be = 4'b0100; byte_rdata = ram_rdata[23:16]; end
      default: begin word_be = 4'b1000; byte_rdata = ram_rdata[31:24]; end
    endcase
  end

endmodule

// File: rtl/twpm_ram_arbiter.sv
// Two-port arbiter for the TWPM buffer RAM: byte port A (LPC registers)
// and word port B (M4), round-robin on contention, A rejected while B holds the lock.
//
// state         | meaning
// --------------+-------------------------------------------------------
// ST_IDLE       | waiting for a request; the only state that grants
// ST_WRITE      | RAM write strobe and requester ack are out this cycle
// ST_RD_ISSUE   | RAM read strobe is out this cycle
// ST_RD_CAPTURE | RAM read data valid; registered into rdata, ack next
// ST_REJECT     | locked port-A access: ack + err + fill byte, no strobe
module twpm_ram_arbiter
  import twpm_ram_pkg::*;
#(
  parameter int         WORD_AW   = WORD_AW_DEF,
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [WORD_AW+1:0] a_addr,
  input  logic [7:0]         a_wdata,
  output logic               a_ack,
  output logic               a_err,
  output logic [7:0]         a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [WORD_AW-1:0] b_addr,
  input  logic [3:0]         b_be,
  input  logic [31:0]        b_wdata,
  output logic               b_ack,
  output logic [31:0]        b_rdata,
  input  logic               b_lock,
  output logic [WORD_AW-1:0] ram_addr,
  output logic [31:0]        ram_wdata,
  output logic [3:0]         ram_be,
  output logic               ram_wr_en,
  output logic               ram_rd_en,
  input  logic [31:0]        ram_rdata
);

  arb_state_e         state;
  port_e              last_grant;
  port_e              cur_port;

  logic [WORD_AW-1:0] lane_addr;
  logic [31:0]        lane_wdata;
  logic [3:0]         lane_be;
  logic [7:0]         lane_rdata;

  logic               a_vld;
  logic               b_vld;
  logic               pick_b;

  twpm_byte_lane #(.WORD_AW(WORD_AW)) u_lane (
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .ram_rdata  (ram_rdata),
    .word_addr  (lane_addr),
    .word_wdata (lane_wdata),
    .word_be    (lane_be),
    .byte_rdata (lane_rdata)
  );

  // A read completes in IDLE with ack high; that held request must not re-grant.
  assign a_vld  = a_req & ~a_ack;
  assign b_vld  = b_req & ~b_ack;
  assign pick_b = b_vld & (~a_vld | (last_grant == PORT_A));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      last_grant <= PORT_B;
      cur_port   <= PORT_A;
      a_ack      <= 1'b0;
      a_err      <= 1'b0;
      a_rdata    <= 8'h00;
      b_ack      <= 1'b0;
      b_rdata    <= 32'h0;
      ram_addr   <= '0;
      ram_wdata  <= 32'h0;
      ram_be     <= 4'b0000;
      ram_wr_en  <= 1'b0;
      ram_rd_en  <= 1'b0;
    end else begin
      a_ack     <= 1'b0;
      a_err     <= 1'b0;
      b_ack     <= 1'b0;
      ram_wr_en <= 1'b0;
      ram_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (a_vld || b_vld) begin
            if (pick_b) begin
              last_grant <= PORT_B;
              cur_port   <= PORT_B;
              ram_addr   <= b_addr;
              if (b_we) begin
                ram_wr_en <= 1'b1;
                ram_wdata <= b_wdata;
                ram_be    <= b_be;
                b_ack     <= 1'b1;
                state     <= ST_WRITE;
              end else begin
                ram_rd_en <= 1'b1;
                ram_be    <= 4'b0000;
                state     <= ST_RD_ISSUE;
              end
            end else begin
              last_grant <= PORT_A;
              cur_port   <= PORT_A;
              // Lock is only looked at here; later changes never touch an access in flight.
              if (b_lock) begin
                a_ack   <= 1'b1;
                a_err   <= 1'b1;
                a_rdata <= FILL_BYTE;
                state   <= ST_REJECT;
              end else begin
                ram_addr <= lane_addr;
                if (a_we) begin
                  ram_wr_en <= 1'b1;
                  ram_wdata <= lane_wdata;
                  ram_be    <= lane_be;
                  a_ack     <= 1'b1;
                  state     <= ST_WRITE;
                end else begin
                  ram_rd_en <= 1'b1;
                  ram_be    <= 4'b0000;
                  state     <= ST_RD_ISSUE;
                end
              end
            end
          end
        end
        ST_WRITE:    state <= ST_IDLE;
        ST_REJECT:   state <= ST_IDLE;
        ST_RD_ISSUE: state <= ST_RD_CAPTURE;
        ST_RD_CAPTURE: begin
          state <= ST_IDLE;
          if (cur_port == PORT_A) begin
            a_rdata <= lane_rdata;
            a_ack   <= 1'b1;
          end else begin
            b_rdata <= ram_rdata;
            b_ack   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twpm_ram_arbiter.sv
// Directed self-checking bench for twpm_ram_arbiter with a behavioural
// 512 x 32 RAM attached to the RAM port.
module tb_twpm_ram_arbiter;

  localparam int WAW = 9;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           a_req, a_we;
  logic [WAW+1:0] a_addr;
  logic [7:0]     a_wdata;
  logic           a_ack, a_err;
  logic [7:0]     a_rdata;
  logic           b_req, b_we;
  logic [WAW-1:0] b_addr;
  logic [3:0]     b_be;
  logic [31:0]    b_wdata;
  logic           b_ack;
  logic [31:0]    b_rdata;
  logic           b_lock;
  logic [WAW-1:0] ram_addr;
  logic [31:0]    ram_wdata;
  logic [3:0]     ram_be;
  logic           ram_wr_en, ram_rd_en;
  logic [31:0]    ram_rdata = 32'h0;

  int tests = 0;
  int fails = 0;

  twpm_ram_arbiter #(.WORD_AW(WAW), .FILL_BYTE(8'hFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_lock(b_lock),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: preloaded on the first edge, read data valid the cycle after rd_en.
  logic [31:0] mem [512];
  bit          mem_loaded = 1'b0;
  always @(posedge clk_i) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 512; k++) mem[k] <= 32'h0;
      mem[1]     <= 32'h11225A44;
      mem_loaded <= 1'b1;
    end else begin
      if (ram_wr_en)
        for (int k = 0; k < 4; k++)
          if (ram_be[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
      if (ram_rd_en) ram_rdata <= mem[ram_addr];
    end
  end

  // Requesters must hold req until the cycle their ack is seen.
  logic a_out = 1'b0, b_out = 1'b0;
  always @(posedge clk_i) begin
    if (rst_i) begin
      a_out <= 1'b0;
      b_out <= 1'b0;
    end else begin
      assert (!(a_out && !a_req && !a_ack)) else begin
        fails++; $error("FAIL a_req_dropped: observed req=0 required req=1 until ack");
      end
      assert (!(b_out && !b_req && !b_ack)) else begin
        fails++; $error("FAIL b_req_dropped: observed req=0 required req=1 until ack");
      end
      assert (!(ram_wr_en && ram_rd_en)) else begin
        fails++; $error("FAIL strobe_overlap: observed wr_en=1 rd_en=1 required not both");
      end
      a_out <= a_req && !a_ack;
      b_out <= b_req && !b_ack;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_write(input logic [WAW+1:0] addr, input logic [7:0] data,
                         input logic [31:0] exp_addr, input logic [31:0] exp_be);
    a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data;
    step();
    chk("aw_wr_en", ram_wr_en, 1);
    chk("aw_rd_en", ram_rd_en, 0);
    chk("aw_addr", ram_addr, exp_addr);
    chk("aw_be", ram_be, exp_be);
    chk("aw_wdata", ram_wdata, {4{data}});
    chk("aw_ack", a_ack, 1);
    chk("aw_err", a_err, 0);
    step();
    a_req = 1'b0;
    chk("aw_ack_done", a_ack, 0);
    chk("aw_wr_en_done", ram_wr_en, 0);
  endtask

  task automatic a_read(input logic [WAW+1:0] addr, input logic [31:0] exp_addr,
                        input logic [31:0] exp_byte);
    a_req = 1'b1; a_we = 1'b0; a_addr = addr;
    step();
    chk("ar_rd_en", ram_rd_en, 1);
    chk("ar_addr", ram_addr, exp_addr);
    chk("ar_ack_c1", a_ack, 0);
    step();
    chk("ar_rd_en_c2", ram_rd_en, 0);
    step();
    chk("ar_ack", a_ack, 1);
    chk("ar_err", a_err, 0);
    chk("ar_rdata", a_rdata, exp_byte);
    a_req = 1'b0;
    step();
    chk("ar_ack_done", a_ack, 0);
  endtask

  task automatic b_write(input logic [WAW-1:0] addr, input logic [3:0] be, input logic [31:0] data);
    b_req = 1'b1; b_we = 1'b1; b_addr = addr; b_be = be; b_wdata = data;
    step();
    chk("bw_wr_en", ram_wr_en, 1);
    chk("bw_addr", ram_addr, {23'b0, addr});
    chk("bw_be", ram_be, {28'b0, be});
    chk("bw_wdata", ram_wdata, data);
    chk("bw_ack", b_ack, 1);
    step();
    b_req = 1'b0;
    chk("bw_ack_done", b_ack, 0);
  endtask

  task automatic b_read(input logic [WAW-1:0] addr, input logic [31:0] exp);
    b_req = 1'b1; b_we = 1'b0; b_addr = addr;
    step();
    chk("br_rd_en", ram_rd_en, 1);
    chk("br_addr", ram_addr, {23'b0, addr});
    chk("br_ack_c1", b_ack, 0);
    step();
    chk("br_ack_c2", b_ack, 0);
    step();
    chk("br_ack", b_ack, 1);
    chk("br_rdata", b_rdata, exp);
    b_req = 1'b0;
    step();
    chk("br_ack_done", b_ack, 0);
    chk("br_rdata_hold", b_rdata, exp);
  endtask

  initial begin
    rst_i = 1'b1; b_lock = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_be = 4'h0; b_wdata = 32'h0;
    step(); step();
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_strobes", {ram_wr_en, ram_rd_en}, 0);
    chk("rst_ram_be", ram_be, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    rst_i = 1'b0;
    step();

    // Basic accesses and lane steering
    b_read(9'd1, 32'h11225A44);
    a_write(11'h006, 8'h5A, 1, 4'b0100);
    b_write(9'd1, 4'b0000, 32'hDEADBEEF);
    b_write(9'd2, 4'b1010, 32'hAABBCCDD);
    b_read(9'd1, 32'h115A5A44);
    b_read(9'd2, 32'hAA00CC00);
    a_read(11'h007, 1, 8'h11);
    a_read(11'h004, 1, 8'h44);

    // Contention straight out of reset: A, B, A, B
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'h008; a_wdata = 8'h01;
    b_req = 1'b1; b_we = 1'b1; b_addr = 9'd3; b_be = 4'hF; b_wdata = 32'h12345678;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("rr_a_ack", a_ack, (i % 4 == 0) ? 32'd1 : 32'd0);
      chk("rr_b_ack", b_ack, (i % 4 == 2) ? 32'd1 : 32'd0);
      if (i % 4 == 0) chk("rr_a_addr", ram_addr, 2);
      if (i % 4 == 2) chk("rr_b_addr", ram_addr, 3);
    end
    b_req = 1'b0;
    step();
    chk("rr_a_wait", a_ack, 0);
    step();
    chk("rr_a_last", a_ack, 1);
    a_req = 1'b0;
    step();

    // Locked port-A read, then a normal B write under lock
    b_lock = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h010;
    step();
    chk("lk_ack", a_ack, 1);
    chk("lk_err", a_err, 1);
    chk("lk_rdata", a_rdata, 8'hFF);
    chk("lk_strobes", {ram_wr_en, ram_rd_en}, 0);
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 9'd4; b_be = 4'hF; b_wdata = 32'hCAFEF00D;
    step();
    chk("lk_ack_done", a_ack, 0);
    chk("lk_err_done", a_err, 0);
    chk("lk_rdata_hold", a_rdata, 8'hFF);
    step();
    chk("lk_bw_ack", b_ack, 1);
    chk("lk_bw_wr_en", ram_wr_en, 1);
    chk("lk_bw_addr", ram_addr, 4);
    chk("lk_bw_wdata", ram_wdata, 32'hCAFEF00D);
    b_req = 1'b0;
    step();

    // Locked port-A write must not reach the RAM
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'h010; a_wdata = 8'h77;
    step();
    chk("lkw_ack", a_ack, 1);
    chk("lkw_err", a_err, 1);
    chk("lkw_wr_en", ram_wr_en, 0);
    a_req = 1'b0;
    b_lock = 1'b0;
    step();
    a_read(11'h010, 4, 8'h0D);

    // Reset during RD_CAPTURE of a B read
    b_req = 1'b1; b_we = 1'b0; b_addr = 9'd1;
    step();
    chk("rc_rd_en", ram_rd_en, 1);
    step();
    rst_i = 1'b1; b_req = 1'b0;
    step();
    chk("rc_b_ack", b_ack, 0);
    chk("rc_b_rdata", b_rdata, 0);
    chk("rc_a_rdata", a_rdata, 0);
    chk("rc_strobes", {ram_wr_en, ram_rd_en}, 0);
    chk("rc_ram_addr", ram_addr, 0);
    chk("rc_ram_wdata", ram_wdata, 0);
    rst_i = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'h000; a_wdata = 8'h33;
    b_req = 1'b1; b_we = 1'b0; b_addr = 9'd1;
    step();
    chk("rc_first_a_ack", a_ack, 1);
    chk("rc_first_b_ack", b_ack, 0);
    chk("rc_first_be", ram_be, 4'b0001);
    a_req = 1'b0;
    step();
    step();
    step();
    step();
    chk("rc_b_ack_late", b_ack, 1);
    chk("rc_b_rdata_late", b_rdata, 32'h115A5A44);
    b_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
